cache_controller: RTL



---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_if.sv | 33 +++
 rtl/cache_memory.sv | 78 +++++++
 rtl/cache_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the two-way set-associative write-through data cache.
// Address split of the local (DATA_BASE-relative) byte address:
//   [2]    word within the 64-bit block
//   [8:3]  set index
//   [18:9] tag
package cache_pkg;

  localparam int TAG_W    = 10;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 3;
  localparam int WAYS     = 2;
  localparam int BLOCK_W  = 64;

  localparam int unsigned DATA_BASE = 1024;

  // Controller state encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_MISS = 2'd1;
  localparam logic [1:0] S_WRITE     = 2'd2;

  // Synchronous update request into the cache arrays. All updates target the
  // set currently presented on the lookup port.
  typedef struct packed {
    logic fill_en;   // allocate the block into the victim way
    logic inv_en;    // clear valid of inv_way
    logic inv_way;
    logic lru_en;    // load lru with lru_way
    logic lru_way;
  } mem_upd_t;

endpackage

// File: rtl/cache_if.sv
// Bus bundle of the cache: MEM-stage request side plus SRAM-controller side.
//   master : the environment (MEM stage and SRAM controller)
//   slave  : the cache controller
// MEM side : mem_r_en, mem_w_en, address, wdata -> ; <- rdata, ready
// SRAM side: sram_rdata, sram_ready -> ; <- sram_r_en, sram_w_en,
//            sram_address, sram_wdata
interface cache_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );

endinterface

// File: rtl/cache_memory.sv
// Tag/valid/data/lru storage for a two-way set-associative cache.
// Ports:
//   clk, rst         clock, async active-high reset (clears valid and lru)
//   lk_index/lk_tag  lookup set and tag
//   lk_word_sel      word of the block returned on lk_word
//   lk_hit/lk_hit_way/lk_word  combinational lookup result
//   upd              synchronous update (fill / invalidate / lru) on lk_index
//   fill_data        block written on fill
// On fill the victim is an invalid way (way0 first), else the lru way;
// lru then points at the other way.
module cache_memory
  import cache_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  lk_index,
  input  logic [TAG_W-1:0]    lk_tag,
  input  logic                lk_word_sel,
  output logic                lk_hit,
  output logic                lk_hit_way,
  output logic [31:0]         lk_word,
  input  mem_upd_t            upd,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0]           lru;
  logic [TAG_W-1:0]          tag_mem  [WAYS][SETS];
  logic [BLOCK_W-1:0]        data_mem [WAYS][SETS];

  logic [WAYS-1:0]    way_hit;
  logic [BLOCK_W-1:0] hit_block;
  logic               victim;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid[lk_index][w] && (tag_mem[w][lk_index] == lk_tag);
  end

  // At most one way can hit, so the hit way is simply way_hit[1].
  assign lk_hit     = |way_hit;
  assign lk_hit_way = way_hit[1];
  assign hit_block  = data_mem[lk_hit_way][lk_index];
  assign lk_word    = lk_word_sel ? hit_block[63:32] : hit_block[31:0];

  always_comb begin
    victim = lru[lk_index];
    if (!valid[lk_index][0])      victim = 1'b0;
    else if (!valid[lk_index][1]) victim = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      lru   <= '0;
    end else begin
      if (upd.fill_en)
        valid[lk_index][victim] <= 1'b1;
      else if (upd.inv_en)
        valid[lk_index][upd.inv_way] <= 1'b0;

      if (upd.fill_en)
        lru[lk_index] <= ~victim;
      else if (upd.lru_en)
        lru[lk_index] <= upd.lru_way;
    end
  end

  // Tag and data need no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (upd.fill_en) begin
      tag_mem[victim][lk_index]  <= lk_tag;
      data_mem[victim][lk_index] <= fill_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache
// between the MEM stage and the SRAM controller.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       cache_if.slave: MEM-stage load/store request with ready
//             (0 = freeze), and the SRAM block-read / word-write handshake
// Read hits complete combinationally in IDLE. Read misses fetch a block and
// bypass the requested word in the sram_ready cycle while filling. Writes
// always go to SRAM; a write hit only invalidates the cached line.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned DATA_BASE = cache_pkg::DATA_BASE,
  parameter int          SETS      = 64
) (
  input  logic   clk,
  input  logic   rst,
  cache_if.slave bus
);

  localparam int IDX_LO = OFFSET_W;
  localparam int TAG_LO = OFFSET_W + INDEX_W;

  logic [1:0]         state, state_nxt;
  logic [31:0]        a;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               word_sel;
  logic               addr_unused;

  logic        hit, hit_way;
  logic [31:0] hit_word;
  mem_upd_t    upd;

  assign a        = bus.address - 32'(DATA_BASE);
  assign word_sel = a[OFFSET_W-1];
  assign index    = a[TAG_LO-1:IDX_LO];
  assign tag      = a[TAG_LO+TAG_W-1:TAG_LO];
  // Byte offset and bits above the tag carry no information.
  assign addr_unused = ^{a[31:TAG_LO+TAG_W], a[OFFSET_W-2:0]};

  // Address and data are held stable by the freeze, so they go straight out.
  assign bus.sram_address = bus.address;
  assign bus.sram_wdata   = bus.wdata;

  cache_memory #(.SETS(SETS)) u_mem (
    .clk         (clk),
    .rst         (rst),
    .lk_index    (index),
    .lk_tag      (tag),
    .lk_word_sel (word_sel),
    .lk_hit      (hit),
    .lk_hit_way  (hit_way),
    .lk_word     (hit_word),
    .upd         (upd),
    .fill_data   (bus.sram_rdata)
  );

  always_comb begin
    state_nxt     = state;
    bus.ready     = 1'b0;
    bus.rdata     = '0;
    bus.sram_r_en = 1'b0;
    bus.sram_w_en = 1'b0;
    upd           = '0;
    upd.inv_way   = hit_way;
    upd.lru_way   = ~hit_way;
    unique case (state)
      S_IDLE: begin
        // Store wins when both enables are high.
        if (bus.mem_w_en) begin
          state_nxt  = S_WRITE;
          upd.inv_en = hit;
        end else if (bus.mem_r_en) begin
          if (hit) begin
            bus.ready  = 1'b1;
            bus.rdata  = hit_word;
            upd.lru_en = 1'b1;
          end else begin
            state_nxt = S_READ_MISS;
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      S_READ_MISS: begin
        bus.sram_r_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready   = 1'b1;
          bus.rdata   = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
          upd.fill_en = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_WRITE: begin
        bus.sram_w_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

endmodule
